// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the lsu_word_bridge load/store unit.
//
// Contents:
//   size_e      - access size (byte, half, word)
//   state_e     - bridge FSM states
//   F3_*        - funct3 encodings of the core's load instructions
//   decode_size - maps the raw 2-bit request size onto size_e (2'b11 -> word)
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } state_e;

   // funct3 -> (size, unsigned): size is funct3[1:0], unsigned is funct3[2].
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic size_e decode_size(input logic [1:0] raw);
      case (raw)
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational byte-lane logic for the load/store bridge.
//
// Ports:
//   word_i      - 32-bit word read from memory
//   addr_i      - low two bits of the byte address (lane select)
//   size_i      - access size
//   unsigned_i  - zero-extend instead of sign-extend
//   wdata_i     - store data (low byte/half used for sub-word stores)
//   load_data_o - extracted and extended load value
//   merged_o    - word_i with the addressed lane(s) replaced by wdata_i
//
// Lanes are little-endian; low address bits below the access size are
// ignored, so a misaligned access is treated as aligned down.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  size_e       size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v      = word_i[{addr_i, 3'b000} +: 8];
      half_v      = addr_i[1] ? word_i[31:16] : word_i[15:0];
      load_data_o = word_i;
      merged_o    = word_i;
      case (size_i)
         SZ_B: begin
            load_data_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
            merged_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_H: begin
            load_data_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
            if (addr_i[1]) begin
               merged_o[31:16] = wdata_i[15:0];
            end else begin
               merged_o[15:0] = wdata_i[15:0];
            end
         end
         default: begin
            load_data_o = word_i;
            merged_o    = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu_word_bridge.sv
// lsu_word_bridge: converts byte/half/word load and store requests from the
// core's memory stage into accesses on a word-wide synchronous-read memory.
// Loads are extracted and sign/zero-extended; sub-word stores are done as a
// read-modify-write. Exactly one response per accepted request.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   req_*         - request channel (valid/ready, store, size, unsigned,
//                   byte address, write data)
//   resp_*        - one-cycle response pulse (rdata, err), no backpressure
//   mem_*         - word memory: registered addr/re/we/wdata, rdata returned
//                   the cycle after mem_re
//   dbg_state_o   - current FSM state, for observation only
//
// Handshake: a request is taken on a rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so it stays low
// for the whole transaction. resp_valid is a single-cycle pulse that the
// requester must take; there is no resp_ready.
//
// Build option: define LSU_MISALIGN_TRAP_EN to answer misaligned half/word
// requests with resp_err=1 and no memory access. Without it, misaligned
// requests are aligned down and resp_err never rises.
module lsu_word_bridge
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-3:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output state_e            dbg_state_o
);

   generate
      if (DATA_W != 32) begin : g_bad_data_w
         $error("lsu_word_bridge: DATA_W must be 32");
      end
   endgenerate

   state_e              state_q, state_d;
   logic                mem_re_q, mem_re_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
   logic                resp_err_q, resp_err_d;

   // Request fields held for the duration of the transaction.
   logic                store_q, store_d;
   size_e               size_q, size_d;
   logic                uns_q, uns_d;
   logic [1:0]          addr_lo_q, addr_lo_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   size_e               req_size_n;
   logic                misalign;
   logic [DATA_W-1:0]   load_data;
   logic [DATA_W-1:0]   merged;

   assign req_size_n = decode_size(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (req_size_n)
         SZ_H:    misalign = req_addr[0];
         SZ_W:    misalign = |req_addr[1:0];
         default: misalign = 1'b0;
      endcase
   end
`else
   // Misaligned requests are simply aligned down; the trap path is never
   // taken, so resp_err_q stays at its reset value of 0.
   assign misalign = 1'b0;
`endif

   // Memory data is consumed combinationally in WAIT, the cycle it is valid.
   lsu_lane u_lane (
      .word_i      (mem_rdata),
      .addr_i      (addr_lo_q),
      .size_i      (size_q),
      .unsigned_i  (uns_q),
      .wdata_i     (wdata_q),
      .load_data_o (load_data),
      .merged_o    (merged)
   );

   always_comb begin
      state_d      = state_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;
      store_d      = store_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_lo_d    = addr_lo_q;
      wdata_d      = wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               store_d   = req_store;
               size_d    = req_size_n;
               uns_d     = req_unsigned;
               addr_lo_d = req_addr[1:0];
               wdata_d   = req_wdata;
               if (misalign) begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  mem_addr_d = req_addr[ADDR_W-1:2];
                  if (req_store && (req_size_n == SZ_W)) begin
                     // Full-word store needs no read.
                     state_d     = ST_WR;
                     mem_we_d    = 1'b1;
                     mem_wdata_d = req_wdata;
                  end else begin
                     state_d  = ST_RD;
                     mem_re_d = 1'b1;
                  end
               end
            end
         end
         ST_RD: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (store_q) begin
               state_d     = ST_WR;
               mem_we_d    = 1'b1;
               mem_wdata_d = merged;
            end else begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data;
            end
         end
         ST_WR: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         store_q      <= 1'b0;
         size_q       <= SZ_B;
         uns_q        <= 1'b0;
         addr_lo_q    <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         store_q      <= store_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_lo_q    <= addr_lo_d;
         wdata_q      <= wdata_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign mem_addr    = mem_addr_q;
   assign mem_re      = mem_re_q;
   assign mem_we      = mem_we_q;
   assign mem_wdata   = mem_wdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_word_bridge.sv
// Bench for lsu_word_bridge: directed requests against a small word memory,
// a reference model computing responses, strobes and ready from the access
// rules, and literal expectations for each directed vector.
module tb_lsu_word_bridge;

   localparam int ADDR_W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_store = 1'b0;
   logic [1:0]        req_size = 2'b00;
   logic              req_unsigned = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-3:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   lsu_pkg::state_e   dbg_state;

   lsu_word_bridge #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_store    (req_store),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_re       (mem_re),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .dbg_state_o  (dbg_state)
   );

   // ---------------- memory (environment) ----------------
   logic [31:0] mem [0:255];
   logic [31:0] rdata_r;
   logic        mem_init = 1'b1;
   assign mem_rdata = rdata_r;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[64] <= 32'h8899AABB;  // byte address 0x100
         rdata_r <= 32'h0;
      end else begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
         if (mem_re) rdata_r <= mem[mem_addr[7:0]];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_err = 0;
   bit active = 1'b0;
   int last_t = 0;

   logic [31:0] ref_mem [0:255];
   logic [31:0] exp_q[$];
   int          exp_cyc_q[$];
   bit          exp_err_q[$];
   bit          exp_busy[int];
   logic [29:0] exp_re_a[int];
   logic [29:0] exp_we_a[int];
   logic [31:0] exp_we_d[int];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   function automatic int nbytes_of(input logic [1:0] sz);
      if (sz == 2'b00) return 1;
      if (sz == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input int lane,
                                            input int nb, input bit uns);
      logic [63:0] v;
      v = ({32'h0, w} >> (8 * lane)) & ((64'd1 << (8 * nb)) - 64'd1);
      if (!uns && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
      return v[31:0];
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] w, input int lane,
                                             input int nb, input logic [31:0] wd);
      for (int b = 0; b < nb; b++) w[8 * (lane + b) +: 8] = wd[8 * b +: 8];
      return w;
   endfunction

   task automatic push_resp(input int c, input logic [31:0] d, input bit e);
      exp_cyc_q.push_back(c);
      exp_q.push_back(d);
      exp_err_q.push_back(e);
   endtask

   task automatic flush_model();
      exp_q.delete();
      exp_cyc_q.delete();
      exp_err_q.delete();
      exp_busy.delete();
      exp_re_a.delete();
      exp_we_a.delete();
      exp_we_d.delete();
   endtask

   // ---------------- driver ----------------
   task automatic do_req(input bit st, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd);
      int nb, lane, t, n;
      bit trap;
      logic [29:0] wa;
      logic [31:0] w;
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         n_checks++; n_err++;
         $display("FAIL accept_timeout: req_ready=%b required=1", req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      t = cyc - 1;
      last_t = t;
      nb = nbytes_of(sz);
      lane = (int'(addr[1:0]) / nb) * nb;
      trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = (int'(addr[1:0]) % nb) != 0;
`endif
      wa = addr[31:2];
      w = ref_mem[addr[9:2]];
      if (trap) begin
         exp_busy[t + 1] = 1'b1;
         push_resp(t + 1, 32'h0, 1'b1);
      end else if (st && nb == 4) begin
         exp_busy[t + 1] = 1'b1;
         exp_we_a[t + 1] = wa;
         exp_we_d[t + 1] = wd;
         ref_mem[addr[9:2]] = wd;
         push_resp(t + 2, 32'h0, 1'b0);
      end else if (st) begin
         for (int k = 1; k <= 3; k++) exp_busy[t + k] = 1'b1;
         w = ref_merge(w, lane, nb, wd);
         exp_re_a[t + 1] = wa;
         exp_we_a[t + 3] = wa;
         exp_we_d[t + 3] = w;
         ref_mem[addr[9:2]] = w;
         push_resp(t + 4, 32'h0, 1'b0);
      end else begin
         for (int k = 1; k <= 2; k++) exp_busy[t + k] = 1'b1;
         exp_re_a[t + 1] = wa;
         push_resp(t + 3, ref_load(w, lane, nb, uns), 1'b0);
      end
   endtask

   // Waits for the response of the last request; checks hand-computed values.
   task automatic expect_resp(input string name, input logic [31:0] lit,
                              input bit lit_err, input int lit_lat);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            check({name, "_data"}, resp_rdata, lit);
            check({name, "_err"}, resp_err, lit_err);
            check({name, "_lat"}, cyc - last_t, lit_lat);
            return;
         end
      end
      n_checks++; n_err++;
      $display("FAIL %s_timeout: resp_valid=0 required=1", name);
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (active) begin
         check("req_ready", req_ready, !exp_busy.exists(cyc));
         check("mem_re", mem_re, exp_re_a.exists(cyc));
         if (exp_re_a.exists(cyc)) check("mem_addr_rd", mem_addr, exp_re_a[cyc]);
         check("mem_we", mem_we, exp_we_a.exists(cyc));
         if (exp_we_a.exists(cyc)) begin
            check("mem_addr_wr", mem_addr, exp_we_a[cyc]);
            check("mem_wdata", mem_wdata, exp_we_d[cyc]);
         end
         if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
            check("resp_valid", resp_valid, 1);
            check("resp_rdata", resp_rdata, exp_q[0]);
            check("resp_err", resp_err, exp_err_q[0]);
            void'(exp_cyc_q.pop_front());
            void'(exp_q.pop_front());
            void'(exp_err_q.pop_front());
         end else begin
            check("resp_valid_idle", resp_valid, 0);
            check("resp_err_idle", resp_err, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int t1;
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      ref_mem[64] = 32'h8899AABB;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_state", dbg_state, 0);
      rst = 1'b0;
      mem_init = 1'b0;
      active = 1'b1;

      // Loads from the preloaded word 0x8899AABB.
      do_req(0, 2'b00, 0, 32'h101, 0); expect_resp("lb_101",  32'hFFFFFFAA, 0, 3);
      do_req(0, 2'b00, 1, 32'h101, 0); expect_resp("lbu_101", 32'h000000AA, 0, 3);
      do_req(0, 2'b01, 0, 32'h102, 0); expect_resp("lh_102",  32'hFFFF8899, 0, 3);
      do_req(0, 2'b01, 1, 32'h102, 0); expect_resp("lhu_102", 32'h00008899, 0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
      do_req(0, 2'b01, 0, 32'h101, 0); expect_resp("lh_101",  32'h00000000, 1, 1);
`else
      do_req(0, 2'b01, 0, 32'h101, 0); expect_resp("lh_101",  32'hFFFFAABB, 0, 3);
`endif
      do_req(0, 2'b00, 0, 32'h100, 0); expect_resp("lb_100",  32'hFFFFFFBB, 0, 3);
      do_req(0, 2'b00, 1, 32'h103, 0); expect_resp("lbu_103", 32'h00000088, 0, 3);
      do_req(0, 2'b10, 0, 32'h100, 0); expect_resp("lw_100",  32'h8899AABB, 0, 3);
      do_req(0, 2'b11, 0, 32'h100, 0); expect_resp("l11_100", 32'h8899AABB, 0, 3);

      // Sub-word stores (read-modify-write).
      do_req(1, 2'b00, 0, 32'h103, 32'h12345611); expect_resp("sb_103", 32'h0, 0, 4);
      do_req(0, 2'b10, 0, 32'h100, 0); expect_resp("lw_after_sb", 32'h1199AABB, 0, 3);
      do_req(1, 2'b01, 0, 32'h106, 32'hCAFEBEEF); expect_resp("sh_106", 32'h0, 0, 4);
      do_req(0, 2'b10, 0, 32'h104, 0); expect_resp("lw_after_sh", 32'hBEEF0000, 0, 3);

      // Back-to-back word stores.
      do_req(1, 2'b10, 0, 32'h100, 32'hDEADBEEF);
      t1 = last_t;
      do_req(1, 2'b10, 0, 32'h104, 32'h01234567);
      check("b2b_spacing", last_t - t1, 2);
      expect_resp("sw_104", 32'h0, 0, 2);
      do_req(0, 2'b10, 0, 32'h100, 0); expect_resp("lw_after_sw", 32'hDEADBEEF, 0, 3);

      // Reset during WAIT of a load: no response.
      do_req(0, 2'b10, 0, 32'h104, 0);
      @(negedge clk);  // RD
      @(negedge clk);  // WAIT
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush_model();
      @(negedge clk);
      check("postrst_ready", req_ready, 1);
      check("postrst_mem_re", mem_re, 0);
      check("postrst_mem_we", mem_we, 0);
      check("postrst_resp_valid", resp_valid, 0);
      repeat (3) @(negedge clk);

      do_req(0, 2'b00, 0, 32'h102, 0); expect_resp("lb_after_rst", 32'hFFFFFFAD, 0, 3);
      do_req(0, 2'b01, 1, 32'h106, 0); expect_resp("lhu_106", 32'h00000123, 0, 3);

      repeat (3) @(negedge clk);
      check("resp_drain", exp_cyc_q.size(), 0);
      active = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
